// File: rtl/radar_frame_packer.sv
// Collects CHANNELS serial samples into one wide beat and tags it with row/column/frame
// indices and start/end markers, scanning frames in raster or column-major order.
module radar_frame_packer #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_NUM    = 4,
    parameter int IMG_ROWS     = 2048,
    parameter int IMG_COLS     = 2048,
    parameter int POINTS       = 2,
    parameter int CH_PER_POINT = 5,
    localparam int ROW_W       = $clog2(IMG_ROWS),
    localparam int COL_W       = $clog2(IMG_COLS),
    localparam int CHANNELS    = POINTS * CH_PER_POINT,
    localparam int FRM_W       = $clog2(FRAME_NUM + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ROW_W:0]                 cfg_rows,
    input  logic [COL_W:0]                 cfg_cols,
    input  logic [FRM_W-1:0]               cfg_frames,
    input  logic                           cfg_col_major,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*CHANNELS-1:0] pixel_out,
    output logic [ROW_W-1:0]               row_idx,
    output logic [COL_W-1:0]               col_idx,
    output logic [FRM_W-1:0]               frame_idx,
    output logic [1:0]                     data_start,
    output logic [1:0]                     data_end,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

    localparam int WORD_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(CHANNELS - 1);
    localparam logic [ROW_W:0]    MAX_ROWS   = (ROW_W + 1)'(IMG_ROWS);
    localparam logic [COL_W:0]    MAX_COLS   = (COL_W + 1)'(IMG_COLS);
    localparam logic [COL_W:0]    PTS        = (COL_W + 1)'(POINTS);
    localparam logic [FRM_W-1:0]  MAX_FRAMES = FRM_W'(FRAME_NUM);

    state_t                         state_q, state_d;
    logic [ROW_W:0]                 rows_q, rows_d;
    logic [COL_W:0]                 cols_q, cols_d;
    logic [FRM_W-1:0]               frames_q, frames_d;
    logic                           col_major_q, col_major_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic [COL_W-1:0]               col_q, col_d;
    logic [FRM_W-1:0]               frame_q, frame_d;
    logic [WORD_W-1:0]              word_q, word_d;
    logic [DATA_WIDTH*CHANNELS-1:0] pixel_q, pixel_d;
    logic                           out_valid_q, out_valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           cfg_err_q, cfg_err_d;

    logic [ROW_W:0] row_nxt;
    logic [COL_W:0] col_nxt;
    logic           row_wrap, col_wrap, last_pos, last_beat, cfg_ok;

    // The final position is (rows-1, cols-POINTS) in both scan orders.
    assign row_nxt   = {1'b0, row_q} + 1'b1;
    assign col_nxt   = {1'b0, col_q} + PTS;
    assign row_wrap  = (row_nxt == rows_q);
    assign col_wrap  = (col_nxt == cols_q);
    assign last_pos  = row_wrap && col_wrap;
    assign last_beat = last_pos && (frame_q == frames_q - 1'b1);

    assign cfg_ok = (cfg_rows != '0) && (cfg_rows <= MAX_ROWS) &&
                    (cfg_cols != '0) && (cfg_cols <= MAX_COLS) &&
                    ((cfg_cols % PTS) == '0) &&
                    (cfg_frames != '0) && (cfg_frames <= MAX_FRAMES);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        frames_d    = frames_q;
        col_major_d = col_major_q;
        row_d       = row_q;
        col_d       = col_q;
        frame_d     = frame_q;
        word_d      = word_q;
        pixel_d     = pixel_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        rows_d      = cfg_rows;
                        cols_d      = cfg_cols;
                        frames_d    = cfg_frames;
                        col_major_d = cfg_col_major;
                        row_d       = '0;
                        col_d       = '0;
                        frame_d     = '0;
                        word_d      = '0;
                        state_d     = FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    pixel_d[int'(word_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = EMIT;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!col_major_q) begin
                        if (col_wrap) begin
                            col_d = '0;
                            if (row_wrap) begin
                                row_d   = '0;
                                frame_d = frame_q + 1'b1;
                            end else begin
                                row_d = row_nxt[ROW_W-1:0];
                            end
                        end else begin
                            col_d = col_nxt[COL_W-1:0];
                        end
                    end else begin
                        if (row_wrap) begin
                            row_d = '0;
                            if (col_wrap) begin
                                col_d   = '0;
                                frame_d = frame_q + 1'b1;
                            end else begin
                                col_d = col_nxt[COL_W-1:0];
                            end
                        end else begin
                            row_d = row_nxt[ROW_W-1:0];
                        end
                    end
                    state_d = last_beat ? DONE : FILL;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over any same-cycle handshake and drops a partial word group.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            word_d  = '0;
        end

        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            frames_q    <= '0;
            col_major_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            frame_q     <= '0;
            word_q      <= '0;
            pixel_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            frames_q    <= frames_d;
            col_major_q <= col_major_d;
            row_q       <= row_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            word_q      <= word_d;
            pixel_q     <= pixel_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = out_valid_q;
    assign pixel_out = pixel_q;
    assign row_idx   = row_q;
    assign col_idx   = col_q;
    assign frame_idx = frame_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

    // Flags are gated by out_valid so they read zero outside a presented beat.
    always_comb begin
        data_start    = 2'b00;
        data_end      = 2'b00;
        data_start[0] = out_valid_q && (row_q == '0) && (col_q == '0);
        data_start[1] = data_start[0] && (frame_q == '0);
        data_end[0]   = out_valid_q && last_pos;
        data_end[1]   = data_end[0] && (frame_q == frames_q - 1'b1);
    end

endmodule

// File: tb/tb_radar_frame_packer.sv
// Randomized self-checking bench for radar_frame_packer against a scan-order reference model.
module tb_radar_frame_packer;

    localparam int DW       = 16;
    localparam int FRAME_NUM = 4;
    localparam int IMG_ROWS = 8;
    localparam int IMG_COLS = 8;
    localparam int POINTS   = 2;
    localparam int CPP      = 2;
    localparam int CH       = POINTS * CPP;
    localparam int ROW_W    = $clog2(IMG_ROWS);
    localparam int COL_W    = $clog2(IMG_COLS);
    localparam int FRM_W    = $clog2(FRAME_NUM + 1);
    localparam int PIX_W    = DW * CH;

    logic             clock = 1'b0;
    logic             reset, start, abort, cfg_col_major, in_valid, out_ready;
    logic [ROW_W:0]   cfg_rows;
    logic [COL_W:0]   cfg_cols;
    logic [FRM_W-1:0] cfg_frames;
    logic [DW-1:0]    in_data;
    logic             in_ready, out_valid, busy, done, cfg_err;
    logic [PIX_W-1:0] pixel_out;
    logic [ROW_W-1:0] row_idx;
    logic [COL_W-1:0] col_idx;
    logic [FRM_W-1:0] frame_idx;
    logic [1:0]       data_start, data_end;

    radar_frame_packer #(
        .DATA_WIDTH(DW), .FRAME_NUM(FRAME_NUM), .IMG_ROWS(IMG_ROWS),
        .IMG_COLS(IMG_COLS), .POINTS(POINTS), .CH_PER_POINT(CPP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_frames(cfg_frames),
        .cfg_col_major(cfg_col_major), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .pixel_out(pixel_out), .row_idx(row_idx), .col_idx(col_idx),
        .frame_idx(frame_idx), .data_start(data_start), .data_end(data_end),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PIX_W-1:0] pix;
        int               row;
        int               col;
        int               frame;
        logic [1:0]       ds;
        logic [1:0]       de;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] samples[];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_exp(input beat_t b);
        return 128'({b.pix, ROW_W'(b.row), COL_W'(b.col), FRM_W'(b.frame), b.ds, b.de});
    endfunction

    function automatic logic [127:0] pack_obs();
        return 128'({pixel_out, row_idx, col_idx, frame_idx, data_start, data_end});
    endfunction

    function automatic logic [127:0] pack_all();
        return 128'({out_valid, in_ready, busy, done, cfg_err, pixel_out,
                     row_idx, col_idx, frame_idx, data_start, data_end});
    endfunction

    // Expected beats follow directly from nested scan loops over the frame geometry.
    task automatic build_model(input int rows, input int cols, input int frames,
                               input bit cm, input bit seq);
        int n, k;
        n = rows * (cols / POINTS) * frames;
        samples = new[n * CH];
        foreach (samples[i]) samples[i] = seq ? DW'(i) : DW'($urandom);
        exp_q.delete();
        k = 0;
        for (int f = 0; f < frames; f++) begin
            for (int a = 0; a < (cm ? cols / POINTS : rows); a++) begin
                for (int b = 0; b < (cm ? rows : cols / POINTS); b++) begin
                    beat_t bt;
                    bt.row   = cm ? b : a;
                    bt.col   = (cm ? a : b) * POINTS;
                    bt.frame = f;
                    for (int w = 0; w < CH; w++) bt.pix[w*DW +: DW] = samples[k*CH + w];
                    bt.ds[0] = (bt.row == 0) && (bt.col == 0);
                    bt.ds[1] = bt.ds[0] && (f == 0);
                    bt.de[0] = (bt.row == rows - 1) && (bt.col == cols - POINTS);
                    bt.de[1] = bt.de[0] && (f == frames - 1);
                    exp_q.push_back(bt);
                    k++;
                end
            end
        end
    endtask

    task automatic do_start(input int rows, input int cols, input int frames, input bit cm);
        @(negedge clock);
        start         = 1'b1;
        cfg_rows      = (ROW_W + 1)'(rows);
        cfg_cols      = (COL_W + 1)'(cols);
        cfg_frames    = FRM_W'(frames);
        cfg_col_major = cm;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic feed(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            in_valid = 1'b1;
            in_data  = samples[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!out_valid) check(tag, 0, 1);
    endtask

    task automatic run_seq(input int rows, input int cols, input int frames, input bit cm,
                           input bit seq, input int stall_pct, input bit check_rate);
        int  n, fed, got, cycles;
        bit  bad, done_seen;
        build_model(rows, cols, frames, cm, seq);
        n = exp_q.size();
        do_start(rows, cols, frames, cm);
        check("start_to_fill", {busy, in_ready}, 2'b11);
        fed = 0; got = 0; cycles = 1; bad = 0; done_seen = 0;
        while (!done_seen && cycles < 5000) begin
            if (done) begin
                done_seen = 1;
                break;
            end
            if ((out_valid && in_ready) || cfg_err) bad = 1;
            start = 1'b0;
            if (stall_pct > 0 && $urandom_range(0, 19) == 0) begin
                start      = 1'b1;
                cfg_cols   = (COL_W + 1)'(3);
                cfg_frames = '0;
            end
            out_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("beat_extra", 1, 0);
                else check("beat", pack_obs(), pack_exp(exp_q.pop_front()));
                got++;
            end
            if (fed < samples.size() && ((stall_pct == 0) || $urandom_range(0, 99) >= stall_pct)) begin
                in_valid = 1'b1;
                in_data  = samples[fed];
                if (in_ready) fed++;
            end else begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
            @(negedge clock);
            cycles++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("done_seen", done_seen, 1);
        check("beats_before_done", got, n);
        check("no_in_ready_or_err_while_emit", bad, 0);
        if (check_rate) check("throughput_cycles", cycles, n * (CH + 1) + 1);
        @(negedge clock);
        check("done_one_cycle", {done, busy}, 2'b00);
    endtask

    initial begin
        int rows_t[7]   = '{2, 2, 0, 9, 2, 2, 2};
        int cols_t[7]   = '{3, 4, 4, 4, 0, 10, 4};
        int frames_t[7] = '{2, 0, 1, 1, 1, 1, 5};
        bit err_seen;

        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; cfg_rows = '0; cfg_cols = '0; cfg_frames = '0; cfg_col_major = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_state", pack_all(), 0);
        reset = 1'b0;

        // Directed raster and column-major sequences with counting samples.
        run_seq(2, 4, 2, 0, 1, 0, 1);
        run_seq(2, 4, 2, 1, 1, 0, 1);

        // Backpressure on a single-beat sequence (first and last beat at once).
        build_model(1, 2, 1, 0, 0);
        do_start(1, 2, 1, 0);
        feed(CH);
        wait_valid("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            check("bp_hold", pack_obs(), pack_exp(exp_q[0]));
            check("bp_in_ready_low", in_ready, 0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("bp_done_after_one", {done, out_valid}, 2'b10);
        @(negedge clock);

        // Illegal configurations.
        for (int i = 0; i < 7; i++) begin
            do_start(rows_t[i], cols_t[i], frames_t[i], 0);
            check("cfg_err_pulse", {cfg_err, busy, out_valid}, 3'b100);
            @(negedge clock);
            check("cfg_err_clear", {cfg_err, busy, out_valid}, 3'b000);
        end

        // Largest legal frame set with random stalls.
        run_seq(8, 8, 4, 0, 0, 30, 0);

        // Abort after 3 of 4 words, then a fresh sequence.
        build_model(2, 4, 1, 0, 0);
        do_start(2, 4, 1, 0);
        feed(3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_fill_idle", {busy, out_valid, in_ready}, 3'b000);
        err_seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (done || out_valid) err_seen = 1;
        end
        check("abort_no_done", err_seen, 0);
        run_seq(2, 4, 1, 0, 0, 0, 1);

        // Abort during EMIT wins over the same-cycle handshake.
        build_model(1, 2, 1, 0, 0);
        do_start(1, 2, 1, 0);
        feed(CH);
        wait_valid("abort_emit_timeout");
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_emit_idle", {busy, out_valid, done}, 3'b000);
        @(negedge clock);
        check("abort_emit_no_done", done, 0);

        // Reset in EMIT, then start masked by reset.
        build_model(2, 4, 1, 0, 0);
        do_start(2, 4, 1, 0);
        feed(CH);
        wait_valid("reset_emit_timeout");
        reset = 1'b1;
        @(negedge clock);
        check("reset_in_emit", pack_all(), 0);
        start = 1'b1; cfg_rows = 2; cfg_cols = 4; cfg_frames = 1;
        @(negedge clock);
        start = 1'b0; reset = 1'b0;
        check("start_with_reset_ignored", busy, 0);
        @(negedge clock);
        check("still_idle", {busy, cfg_err}, 2'b00);

        // Randomized configurations.
        for (int i = 0; i < 6; i++) begin
            run_seq($urandom_range(1, IMG_ROWS), POINTS * $urandom_range(1, IMG_COLS / POINTS),
                    $urandom_range(1, FRAME_NUM), 1'($urandom_range(0, 1)), 0,
                    $urandom_range(0, 50), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
